// File: rtl/axi_w_router.sv
// AXI write-data channel router.
// Steers one master W channel to one of NUM_SLV slave W channels, or to an
// internal decode-error sink. The burst order comes from a small order FIFO
// that the AW arbiter fills with (target, len) on every accepted AW handshake.
// A beat counter checks that WLAST_M appears exactly on beat len of each burst.
module axi_w_router #(
    parameter int NUM_SLV     = 2,
    parameter int DATA_W      = 32,
    parameter int ORDER_DEPTH = 4,
    parameter int LEN_W       = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ord_valid,
    input  logic [2:0]                     ord_slv,
    input  logic [LEN_W-1:0]               ord_len,
    output logic                           ord_ready,
    input  logic [DATA_W-1:0]              WDATA_M,
    input  logic [DATA_W/8-1:0]            WSTRB_M,
    input  logic                           WLAST_M,
    input  logic                           WVALID_M,
    output logic                           WREADY_M,
    output logic [NUM_SLV*DATA_W-1:0]      WDATA_S,
    output logic [NUM_SLV*(DATA_W/8)-1:0]  WSTRB_S,
    output logic [NUM_SLV-1:0]             WLAST_S,
    output logic [NUM_SLV-1:0]             WVALID_S,
    input  logic [NUM_SLV-1:0]             WREADY_S,
    output logic                           dec_err_done,
    output logic                           wlast_err,
    output logic                           busy
);

    localparam int PTR_W  = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
    localparam int STRB_W = DATA_W / 8;
    // Target indices at or above this value address the decode-error sink.
    localparam logic [3:0] SINK_BASE = 4'(NUM_SLV);

    // Order FIFO storage and pointers (one extra wrap bit for full/empty).
    logic [2:0]       r_slv_mem [ORDER_DEPTH];
    logic [LEN_W-1:0] r_len_mem [ORDER_DEPTH];
    logic [PTR_W:0]   r_wptr;
    logic [PTR_W:0]   r_rptr;

    // Burst tracking and status.
    logic [LEN_W-1:0] r_cnt;
    logic             r_wlast_err;
    logic             r_dec_err_done;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_beat;
    logic [2:0]         w_head_slv;
    logic [LEN_W-1:0]   w_head_len;
    logic               w_head_sink;
    logic               w_len_hit;
    logic [NUM_SLV-1:0] w_sel;

    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                         (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign w_head_slv  = r_slv_mem[r_rptr[PTR_W-1:0]];
    assign w_head_len  = r_len_mem[r_rptr[PTR_W-1:0]];
    assign w_head_sink = ({1'b0, w_head_slv} >= SINK_BASE);

    // A pop never frees space for a push in the same cycle.
    assign w_push    = ord_valid && !w_full;
    assign w_beat    = WVALID_M && WREADY_M;
    assign w_pop     = w_beat && WLAST_M;
    assign w_len_hit = (r_cnt == w_head_len);

    assign ord_ready    = !w_full;
    assign busy         = !w_empty;
    assign wlast_err    = r_wlast_err;
    assign dec_err_done = r_dec_err_done;

    // Route master W signals to the slave selected by the FIFO head; others see zeros.
    always_comb begin
        w_sel    = '0;
        WDATA_S  = '0;
        WSTRB_S  = '0;
        WLAST_S  = '0;
        WVALID_S = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            w_sel[i]                        = !w_empty && !w_head_sink && (w_head_slv == 3'(i));
            WVALID_S[i]                     = w_sel[i] && WVALID_M;
            WLAST_S[i]                      = w_sel[i] && WLAST_M;
            WDATA_S[i*DATA_W +: DATA_W]     = w_sel[i] ? WDATA_M : '0;
            WSTRB_S[i*STRB_W +: STRB_W]     = w_sel[i] ? WSTRB_M : '0;
        end
        // The sink swallows beats unconditionally; an empty FIFO stalls the master.
        WREADY_M = !w_empty && (w_head_sink || (|(w_sel & WREADY_S)));
    end

    // Order FIFO: write entries on push, advance pointers on push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < ORDER_DEPTH; i++) begin
                r_slv_mem[i] <= 3'd0;
                r_len_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_slv_mem[r_wptr[PTR_W-1:0]] <= ord_slv;
                r_len_mem[r_wptr[PTR_W-1:0]] <= ord_len;
                r_wptr                       <= r_wptr + (PTR_W+1)'(1);
            end else begin
                r_wptr <= r_wptr;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (PTR_W+1)'(1);
            end else begin
                r_rptr <= r_rptr;
            end
        end
    end

    // Beat counter within the current burst; cleared when WLAST_M is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_pop) begin
            r_cnt <= '0;
        end else if (w_beat) begin
            r_cnt <= r_cnt + LEN_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Sticky flag when WLAST_M disagrees with the expected last beat position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wlast_err <= 1'b0;
        end else if (w_beat && (WLAST_M != w_len_hit)) begin
            r_wlast_err <= 1'b1;
        end else begin
            r_wlast_err <= r_wlast_err;
        end
    end

    // One-cycle pulse after a sink burst completes, for the default B responder.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dec_err_done <= 1'b0;
        end else begin
            r_dec_err_done <= w_pop && w_head_sink;
        end
    end

endmodule

// File: tb/tb_axi_w_router.sv
// Randomised scoreboard bench for axi_w_router.
// Accepted AW orders generate the master beats and the expected slave-side
// beats; a negedge monitor predicts routing from the order queue and compares.
module tb_axi_w_router;

    localparam int NUM_SLV = 2;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;
    localparam int LEN_W   = 4;
    localparam int STRB_W  = DATA_W / 8;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         ord_valid;
    logic [2:0]                   ord_slv;
    logic [LEN_W-1:0]             ord_len;
    logic                         ord_ready;
    logic [DATA_W-1:0]            WDATA_M;
    logic [STRB_W-1:0]            WSTRB_M;
    logic                         WLAST_M;
    logic                         WVALID_M;
    logic                         WREADY_M;
    logic [NUM_SLV*DATA_W-1:0]    WDATA_S;
    logic [NUM_SLV*STRB_W-1:0]    WSTRB_S;
    logic [NUM_SLV-1:0]           WLAST_S;
    logic [NUM_SLV-1:0]           WVALID_S;
    logic [NUM_SLV-1:0]           WREADY_S;
    logic                         dec_err_done;
    logic                         wlast_err;
    logic                         busy;

    axi_w_router #(
        .NUM_SLV(NUM_SLV), .DATA_W(DATA_W), .ORDER_DEPTH(DEPTH), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst),
        .ord_valid(ord_valid), .ord_slv(ord_slv), .ord_len(ord_len), .ord_ready(ord_ready),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
        .WREADY_M(WREADY_M),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
        .WREADY_S(WREADY_S),
        .dec_err_done(dec_err_done), .wlast_err(wlast_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [STRB_W-1:0] s;
        logic              l;
        logic [2:0]        slv;
    } beat_t;

    typedef struct {
        logic [2:0]       slv;
        logic [LEN_W-1:0] len;
    } ord_t;

    beat_t q_mst[$];   // beats the master still has to send
    beat_t q_exp[$];   // beats expected to come out, in order
    ord_t  q_ord[$];   // reference order FIFO

    int n_tests = 0;
    int n_fail  = 0;
    int m_cnt   = 0;
    logic exp_dec = 1'b0;
    logic exp_err = 1'b0;
    int   beats_ovr = 0;
    logic w_en = 1'b0;
    logic w_rand = 1'b0;
    logic taken = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_chk(input string tag);
        check({tag, "_wvalid_s"}, 128'(WVALID_S), 128'(0));
        check({tag, "_wlast_s"},  128'(WLAST_S),  128'(0));
        check({tag, "_wdata_s"},  128'(WDATA_S),  128'(0));
        check({tag, "_wstrb_s"},  128'(WSTRB_S),  128'(0));
        check({tag, "_wready_m"}, 128'(WREADY_M), 128'(0));
        check({tag, "_ord_ready"}, 128'(ord_ready), 128'(1));
        check({tag, "_busy"},     128'(busy),     128'(0));
        check({tag, "_wlast_err"}, 128'(wlast_err), 128'(0));
        check({tag, "_dec_done"}, 128'(dec_err_done), 128'(0));
    endtask

    // Master-side driver: notes accepted beats at negedge.
    always @(negedge clk) begin
        taken = rst && WVALID_M && WREADY_M;
        if (taken && q_mst.size() > 0) void'(q_mst.pop_front());
    end

    // Master-side driver: presents beats and random slave readiness after each edge.
    always @(posedge clk) begin
        #1;
        if (!w_en) begin
            WVALID_M = 1'b0;
        end else if (WVALID_M && !taken) begin
            WVALID_M = 1'b1;
        end else if (q_mst.size() > 0 && $urandom_range(0, 3) != 0) begin
            WVALID_M = 1'b1;
            WDATA_M  = q_mst[0].d;
            WSTRB_M  = q_mst[0].s;
            WLAST_M  = q_mst[0].l;
        end else begin
            WVALID_M = 1'b0;
        end
        WREADY_S = w_rand ? NUM_SLV'($urandom) : '1;
    end

    // Monitor and reference model, evaluated mid-cycle.
    always @(negedge clk) begin
        logic acc, h_ok, h_sink, exp_wr, beat, nxt_dec;
        logic [2:0] h_slv;
        logic [NUM_SLV-1:0] exp_vs, exp_wl;
        logic [NUM_SLV*DATA_W-1:0] exp_wd;
        logic [NUM_SLV*STRB_W-1:0] exp_ws;
        beat_t e;
        ord_t o;
        int nb;
        if (rst) begin
            acc    = ord_valid && (q_ord.size() < DEPTH);
            h_ok   = (q_ord.size() != 0);
            h_slv  = h_ok ? q_ord[0].slv : 3'd0;
            h_sink = h_ok && (int'(h_slv) >= NUM_SLV);
            exp_wr = h_ok && (h_sink ? 1'b1 : WREADY_S[h_slv]);
            exp_vs = (h_ok && !h_sink && WVALID_M) ? (NUM_SLV'(1) << h_slv) : '0;
            check("wready_m", 128'(WREADY_M), 128'(exp_wr));
            check("wvalid_s", 128'(WVALID_S), 128'(exp_vs));
            check("ord_ready", 128'(ord_ready), 128'(q_ord.size() < DEPTH));
            check("busy", 128'(busy), 128'(h_ok));
            check("dec_err_done", 128'(dec_err_done), 128'(exp_dec));
            check("wlast_err", 128'(wlast_err), 128'(exp_err));
            beat    = WVALID_M && exp_wr;
            nxt_dec = 1'b0;
            if (beat && q_exp.size() > 0) begin
                e = q_exp.pop_front();
                exp_wd = '0;
                exp_ws = '0;
                exp_wl = '0;
                if (!h_sink) begin
                    exp_wd[h_slv*DATA_W +: DATA_W] = e.d;
                    exp_ws[h_slv*STRB_W +: STRB_W] = e.s;
                    exp_wl = e.l ? (NUM_SLV'(1) << h_slv) : '0;
                end
                check("wdata_s", 128'(WDATA_S), 128'(exp_wd));
                check("wstrb_s", 128'(WSTRB_S), 128'(exp_ws));
                check("wlast_s", 128'(WLAST_S), 128'(exp_wl));
                if (e.l != (m_cnt == int'(q_ord[0].len))) exp_err = 1'b1;
                if (e.l) begin
                    nxt_dec = h_sink;
                    void'(q_ord.pop_front());
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            exp_dec = nxt_dec;
            if (acc) begin
                o.slv = ord_slv;
                o.len = ord_len;
                q_ord.push_back(o);
                nb = (beats_ovr != 0) ? beats_ovr : int'(ord_len) + 1;
                for (int k = 0; k < nb; k++) begin
                    e.d   = $urandom;
                    e.s   = STRB_W'($urandom);
                    e.l   = (k == nb - 1);
                    e.slv = ord_slv;
                    q_mst.push_back(e);
                    q_exp.push_back(e);
                end
            end
        end
    end

    task automatic push(input logic [2:0] s, input logic [LEN_W-1:0] l, input int nb);
        ord_valid = 1'b1;
        ord_slv   = s;
        ord_len   = l;
        beats_ovr = nb;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        ord_valid = 1'b0;
        beats_ovr = 0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        ord_valid = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (q_ord.size() == 0 && q_mst.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain_occupancy", 128'(q_ord.size()), 128'(0));
        idle(2);
    endtask

    // Asynchronous reset from mid-cycle, checked before any clock edge.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        reset_chk(tag);
        w_en      = 1'b0;
        ord_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        q_ord.delete();
        q_mst.delete();
        q_exp.delete();
        m_cnt   = 0;
        exp_dec = 1'b0;
        exp_err = 1'b0;
        taken   = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
    endtask

    // Orchestration of the test phases.
    initial begin
        rst = 1'b0; ord_valid = 1'b0; ord_slv = 3'd0; ord_len = '0;
        WDATA_M = '0; WSTRB_M = '0; WLAST_M = 1'b0; WVALID_M = 1'b0; WREADY_S = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_chk("por");
        rst = 1'b1;
        @(posedge clk); #1;

        // Random traffic with backpressure, sink targets and push/pop overlap.
        w_en = 1'b1; w_rand = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0)
                push(3'($urandom_range(0, NUM_SLV + 1)), LEN_W'($urandom_range(0, 3)), 0);
            else
                idle(1);
        end
        drain();

        // Back-to-back ordering including a decode-error burst.
        push(3'd0, 4'd0, 0); push(3'd1, 4'd1, 0); push(3'd0, 4'd0, 0);
        push(3'(NUM_SLV), 4'd1, 0);
        drain();

        // Fill the order FIFO with no W traffic; extra pushes are dropped.
        w_en = 1'b0;
        idle(2);
        for (int i = 0; i < DEPTH + 2; i++) push(3'd1, 4'd0, 0);
        idle(1);
        check("full_ord_ready", 128'(ord_ready), 128'(0));
        check("full_busy", 128'(busy), 128'(1));
        w_en = 1'b1; w_rand = 1'b0;
        for (int i = 0; i < 6; i++) push(3'd0, 4'd1, 0);
        drain();

        // Missing WLAST at the expected last beat.
        push(3'd0, 4'd0, 2);
        drain();
        check("missing_last_err", 128'(wlast_err), 128'(1));
        do_reset("rst1");

        // Early WLAST, then reset in the middle of a burst.
        w_en = 1'b1;
        push(3'd1, 4'd2, 2);
        drain();
        check("early_last_err", 128'(wlast_err), 128'(1));
        push(3'd0, 4'd3, 0);
        idle(1);
        for (int c = 0; c < 20; c++) begin
            if (WVALID_M) break;
            idle(1);
        end
        do_reset("rst_mid");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, tests %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
